// File: rtl/idx_to_oh_pipe.sv
// -----------------------------------------------------------------------------
// idx_to_oh_pipe
//
// Registered binary-to-one-hot decoder with a valid/ready stream on each side.
// The incoming index is decoded combinationally (one compare per output bit)
// and the result is stored in a 2-entry FIFO-ordered skid buffer. The head
// entry drives the outputs straight from flops.
//
// DIRECTION matches the core's one-hot-to-index encoder, so a value decoded
// here and re-encoded there returns the original index:
//   "LSB0" : index i sets bit i
//   "MSB0" : index i sets bit NUM_SIGNALS-1-i
// Indices >= NUM_SIGNALS (only reachable when NUM_SIGNALS is not a power of
// two) produce an all-zero vector with out_error=1 and bump error_count.
// NUM_SIGNALS must be at least 2.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset_n      : synchronous active-low reset
//   in_valid     : in_index is valid this cycle
//   in_ready     : block can accept an index (registered, no comb path from
//                  out_ready)
//   in_index     : binary index to decode
//   out_valid    : out_one_hot / out_error are valid
//   out_ready    : consumer accepts the output this cycle
//   out_one_hot  : decoded vector, exactly one bit set or zero on error;
//                  zero whenever out_valid=0
//   out_error    : accepted index was >= NUM_SIGNALS
//   error_count  : saturating (255) count of out-of-range indices accepted
// -----------------------------------------------------------------------------

// One decoder lane: asserts hit when the index equals the constant this bit
// position answers to. Keeping it a plain equality compare means the decoder
// never builds a shifter wider than NUM_SIGNALS.
module idx_to_oh_lane #(
  parameter int INDEX_WIDTH = 2,
  parameter int MATCH_IDX   = 0
) (
  input  logic [INDEX_WIDTH-1:0] idx,
  output logic                   hit
);
  localparam logic [INDEX_WIDTH-1:0] MATCH = INDEX_WIDTH'(MATCH_IDX);

  assign hit = (idx == MATCH);
endmodule

module idx_to_oh_pipe #(
  parameter int    NUM_SIGNALS = 4,
  parameter string DIRECTION   = "LSB0",
  parameter int    INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INDEX_WIDTH-1:0] in_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_SIGNALS-1:0] out_one_hot,
  output logic                   out_error,
  output logic [7:0]             error_count
);

  localparam bit MSB0 = (DIRECTION == "MSB0");

  // One skid entry. Payload fields are kept zero while vld=0 so the head can
  // drive the outputs directly without an output mask.
  typedef struct packed {
    logic                   vld;
    logic                   err;
    logic [NUM_SIGNALS-1:0] oh;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [NUM_SIGNALS-1:0] dec_oh;
  logic                   dec_err;

  for (genvar b = 0; b < NUM_SIGNALS; b++) begin : g_lane
    idx_to_oh_lane #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .MATCH_IDX   (MSB0 ? (NUM_SIGNALS - 1 - b) : b)
    ) u_lane (
      .idx (in_index),
      .hit (dec_oh[b])
    );
  end

  // Every in-range index hits exactly one lane, so "no lane hit" is the same
  // as "index >= NUM_SIGNALS". This avoids a compare that is constant-false
  // for power-of-two sizes.
  assign dec_err = ~|dec_oh;

  // ---------------------------------------------------------------------------
  // Skid buffer state
  // ---------------------------------------------------------------------------
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  entry_t     new_e;
  logic       in_ready_q, in_ready_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       push, pop;

  assign push = in_valid && in_ready_q;
  assign pop  = head_q.vld && out_ready;

  always_comb begin
    new_e     = '0;
    new_e.vld = 1'b1;
    new_e.err = dec_err;
    new_e.oh  = dec_oh;

    head_d = head_q;
    tail_d = tail_q;

    // Pop first: the tail (valid or empty) slides into the head.
    if (pop) begin
      head_d = tail_q;
      tail_d = '0;
    end

    // Then push into the first free slot. With a simultaneous pop this puts
    // the new entry behind whatever remains, preserving order. in_ready_q
    // guarantees a free slot exists whenever push is true.
    if (push) begin
      if (!head_d.vld) head_d = new_e;
      else             tail_d = new_e;
    end

    // Registered ready: next cycle we accept iff fewer than 2 entries remain.
    in_ready_d = !(head_d.vld && tail_d.vld);

    err_cnt_d = err_cnt_q;
    if (push && dec_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
      err_cnt_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all straight from flops
  // ---------------------------------------------------------------------------
  assign in_ready    = in_ready_q;
  assign out_valid   = head_q.vld;
  assign out_one_hot = head_q.oh;
  assign out_error   = head_q.err;
  assign error_count = err_cnt_q;

  // ---------------------------------------------------------------------------
  // Checks
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
    out_valid |-> $onehot0(out_one_hot));

  a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid && !out_error) |-> $onehot(out_one_hot));

  // Tail can only hold data behind a valid head.
  a_order: assert property (@(posedge clk) disable iff (!reset_n)
    tail_q.vld |-> head_q.vld);

  // Empty head must present zeros, never stale data.
  a_zero_idle: assert property (@(posedge clk) disable iff (!reset_n)
    !out_valid |-> (out_one_hot == '0 && !out_error));
`endif

endmodule
